heap_root_ctrl: RTL

Level-0 controller for the pipelined top-K min-heap. Holds the single root record, clears and then releases the heap with `initialize`, and accepts a key stream over valid/ready. Keys strictly greater than the current root replace it and launch a sift-down into the level-1 sorting node with a one-cycle update pulse. It also serves as the level-1 node's upper-record memory, so the heap keeps the largest K = 2^LEVELS − 1 keys seen.

---
 rtl/heap_root_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/heap_root_ctrl.sv
// Level-0 root controller for the pipelined top-K min-heap: clears the heap, holds the root record,
// replaces it with larger keys and launches one sift-down per replacement into level 1.
module heap_root_ctrl #(
  parameter int DATA_W       = 32,
  parameter int LEVELS       = 4,
  parameter int CLEAR_CYCLES = 2 ** (LEVELS - 1),
  parameter int ISSUE_GAP    = 5,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              initialize,
  output logic              update_out,
  output logic              address_updated_out,
  output logic [DATA_W-1:0] root_q,
  input  logic [DATA_W-1:0] root_wr_data,
  input  logic              root_wr_en,
  output logic [DATA_W-1:0] root_min,
  output logic [CNT_W-1:0]  accepted_cnt,
  output logic [CNT_W-1:0]  dropped_cnt
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam int GAP_W = $clog2(ISSUE_GAP + 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {S_CLEAR, S_READY, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] root_d;
  logic              init_q, init_d;
  logic              upd_q, upd_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              handshake;

  // A level-1 write-back owns the root for that cycle, so the key waits.
  assign in_ready  = (state_q == S_READY) && !root_wr_en;
  assign handshake = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    gap_d     = gap_q;
    root_d    = root_q;
    init_d    = init_q;
    upd_d     = 1'b0;
    acc_d     = acc_q;
    drop_d    = drop_q;

    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + CLR_W'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = S_READY;
          init_d    = 1'b1;
          clr_cnt_d = '0;
        end
      end
      S_READY: begin
        if (handshake) begin
          // Strict compare: equal keys would not move in the node's swap test either.
          if (in_data > root_q) begin
            root_d  = in_data;
            upd_d   = 1'b1;
            acc_d   = acc_q + CNT_W'(1);
            gap_d   = GAP_LOAD;
            state_d = S_WAIT;
          end else begin
            drop_d = drop_q + CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_ONE) state_d = S_READY;
      end
      default: state_d = S_CLEAR;
    endcase

    if (state_q != S_CLEAR && root_wr_en) root_d = root_wr_data;

    if (clear_req) begin
      state_d   = S_CLEAR;
      clr_cnt_d = '0;
      root_d    = '0;
      init_d    = 1'b0;
      upd_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      gap_q     <= '0;
      root_q    <= '0;
      init_q    <= 1'b0;
      upd_q     <= 1'b0;
      acc_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      gap_q     <= gap_d;
      root_q    <= root_d;
      init_q    <= init_d;
      upd_q     <= upd_d;
      acc_q     <= acc_d;
      drop_q    <= drop_d;
    end
  end

  assign initialize          = init_q;
  assign update_out          = upd_q;
  assign address_updated_out = 1'b0;
  assign root_min            = root_q;
  assign accepted_cnt        = acc_q;
  assign dropped_cnt         = drop_q;

endmodule
